// File: rtl/sync_fifo_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sync_fifo_param: single-clock FIFO with level, thresholds, sticky errors,  |
// | synchronous flush and optional first-word-fall-through read.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] C_DEPTH = LW'(DEPTH);
  localparam logic [LW-1:0] C_AF    = LW'(AF_LEVEL);
  localparam logic [LW-1:0] C_AE    = LW'(AE_LEVEL);

  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("sync_fifo_param: AF_LEVEL must be in 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_param: AE_LEVEL must be in 0..DEPTH-1");
  end
  if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two >= 2");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              wr_acc, rd_acc;

  // Flags decode the level register only, never same-cycle requests.
  assign full         = (level_q == C_DEPTH);
  assign empty        = (level_q == '0);
  assign almost_full  = (level_q >= C_AF);
  assign almost_empty = (level_q <= C_AE);
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  always_comb begin
    wr_acc      = wr_en && !full && !flush;
    rd_acc      = rd_en && !empty && !flush;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    overflow_d  = (overflow_q && !clr_err) || (wr_en && full && !flush);
    underflow_d = (underflow_q && !clr_err) || (rd_en && empty && !flush);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
      if (wr_acc && !rd_acc)      level_d = level_q + LW'(1);
      else if (rd_acc && !wr_acc) level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; the rst term keeps a write from landing during reset.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) mem_q[wr_ptr_q] <= wr_data;
  end

  if (FWFT != 0) begin : g_fwft
    assign rd_data  = mem_q[rd_ptr_q];
    assign rd_valid = !empty;
  end else begin : g_reg_read
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;

    always_comb begin
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      if (rd_acc) begin
        rd_data_d  = mem_q[rd_ptr_q];
        rd_valid_d = 1'b1;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_data_q  <= rd_data_d;
        rd_valid_q <= rd_valid_d;
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// Bench for sync_fifo_param: registered-read and FWFT instances share stimulus
// and are checked against a queue-based reference model plus fixed vectors.
module tb_sync_fifo_param;

  localparam int DW = 4;
  localparam int DEPTH = 8;
  localparam int AF = 6;
  localparam int AE = 2;

  logic clk = 1'b0;
  logic rst, flush, wr_en, rd_en, clr_err;
  logic [DW-1:0] wr_data;

  logic [DW-1:0] rd_data0, rd_data1;
  logic rd_valid0, rd_valid1;
  logic [3:0] level0, level1;
  logic full0, full1, empty0, empty1, af0, af1, ae0, ae1;
  logic ovf0, ovf1, unf0, unf1;

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .level(level0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .overflow(ovf0), .underflow(unf0), .clr_err(clr_err));

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .level(level1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .overflow(ovf1), .underflow(unf1), .clr_err(clr_err));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of stored words plus the registered-read output.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rd;
  logic m_rv, m_ovf, m_unf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_rd = '0;
    m_rv = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_step(input logic wr, input logic [DW-1:0] wd, input logic rd,
                            input logic fl, input logic ce);
    int n;
    bit was_full, was_empty;
    n = q.size();
    was_full = (n == DEPTH);
    was_empty = (n == 0);
    m_ovf = (m_ovf && !ce) || (!fl && wr && was_full);
    m_unf = (m_unf && !ce) || (!fl && rd && was_empty);
    m_rv = 1'b0;
    if (fl) begin
      q.delete();
    end else begin
      if (rd && !was_empty) begin
        m_rd = q.pop_front();
        m_rv = 1'b1;
      end
      if (wr && !was_full) q.push_back(wd);
    end
  endtask

  task automatic check_model();
    int n;
    n = q.size();
    chk("level", 32'(level0), 32'(n));
    chk("level_fwft", 32'(level1), 32'(n));
    chk("full", 32'(full0), 32'(n == DEPTH));
    chk("empty", 32'(empty0), 32'(n == 0));
    chk("almost_full", 32'(af0), 32'(n >= AF));
    chk("almost_empty", 32'(ae0), 32'(n <= AE));
    chk("overflow", 32'(ovf0), 32'(m_ovf));
    chk("underflow", 32'(unf0), 32'(m_unf));
    chk("overflow_fwft", 32'(ovf1), 32'(m_ovf));
    chk("underflow_fwft", 32'(unf1), 32'(m_unf));
    chk("rd_valid", 32'(rd_valid0), 32'(m_rv));
    chk("rd_data", 32'(rd_data0), 32'(m_rd));
    chk("rd_valid_fwft", 32'(rd_valid1), 32'(n != 0));
    if (n != 0) chk("rd_data_fwft", 32'(rd_data1), 32'(q[0]));
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_level"}, 32'(level0), 32'd0);
    chk({tag, "_empty"}, 32'(empty0), 32'd1);
    chk({tag, "_full"}, 32'(full0), 32'd0);
    chk({tag, "_ae"}, 32'(ae0), 32'd1);
    chk({tag, "_af"}, 32'(af0), 32'd0);
    chk({tag, "_rv"}, 32'(rd_valid0), 32'd0);
    chk({tag, "_rd"}, 32'(rd_data0), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf0), 32'd0);
    chk({tag, "_unf"}, 32'(unf0), 32'd0);
    chk({tag, "_rv_fwft"}, 32'(rd_valid1), 32'd0);
    chk({tag, "_level_fwft"}, 32'(level1), 32'd0);
  endtask

  task automatic cycle(input logic wr, input logic [DW-1:0] wd, input logic rd,
                       input logic fl, input logic ce);
    @(negedge clk);
    wr_en = wr;
    wr_data = wd;
    rd_en = rd;
    flush = fl;
    clr_err = ce;
    @(posedge clk);
    model_step(wr, wd, rd, fl, ce);
    #1;
    check_model();
  endtask

  typedef struct {
    logic          wr;
    logic [DW-1:0] wd;
    logic          rd;
    logic          ce;
    logic [3:0]    exp_level;
    logic          exp_rv;
    logic [DW-1:0] exp_rd;
    logic          exp_unf;
  } vec_t;

  vec_t tbl[10];

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    clr_err = 1'b0;
    wr_data = '0;
    model_reset();

    // Vectors: write 1,2,3, pop three times, then read-while-empty with a write of 5.
    tbl[0] = '{1'b1, 4'd1, 1'b0, 1'b0, 4'd1, 1'b0, 4'd0, 1'b0};
    tbl[1] = '{1'b1, 4'd2, 1'b0, 1'b0, 4'd2, 1'b0, 4'd0, 1'b0};
    tbl[2] = '{1'b1, 4'd3, 1'b0, 1'b0, 4'd3, 1'b0, 4'd0, 1'b0};
    tbl[3] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd2, 1'b1, 4'd1, 1'b0};
    tbl[4] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 1'b1, 4'd2, 1'b0};
    tbl[5] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 4'd3, 1'b0};
    tbl[6] = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b0};
    tbl[7] = '{1'b1, 4'd5, 1'b1, 1'b0, 4'd1, 1'b0, 4'd3, 1'b1};
    tbl[8] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 4'd5, 1'b1};
    tbl[9] = '{1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd5, 1'b0};

    #3;
    check_reset_state("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].wr, tbl[i].wd, tbl[i].rd, 1'b0, tbl[i].ce);
      chk($sformatf("vec%0d_level", i), 32'(level0), 32'(tbl[i].exp_level));
      chk($sformatf("vec%0d_rv", i), 32'(rd_valid0), 32'(tbl[i].exp_rv));
      chk($sformatf("vec%0d_rd", i), 32'(rd_data0), 32'(tbl[i].exp_rd));
      chk($sformatf("vec%0d_unf", i), 32'(unf0), 32'(tbl[i].exp_unf));
    end

    // Fill to full, then overflow and clear it.
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 4'(i), 1'b0, 1'b0, 1'b0);
      chk("fill_af", 32'(af0), 32'((i + 1) >= AF));
    end
    chk("fill_full", 32'(full0), 32'd1);
    chk("fill_level", 32'(level0), 32'd8);
    cycle(1'b1, 4'hE, 1'b0, 1'b0, 1'b0);
    chk("ovf_set", 32'(ovf0), 32'd1);
    chk("ovf_level", 32'(level0), 32'd8);
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    chk("ovf_clr", 32'(ovf0), 32'd0);

    // Drop to four entries, then stream push+pop across the pointer wrap.
    for (int i = 0; i < 4; i++) cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 4'(8 + i), 1'b1, 1'b0, 1'b0);
      chk("stream_level", 32'(level0), 32'd4);
    end
    for (int i = 0; i < 5; i++) cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);

    // First-word-fall-through behaviour.
    cycle(1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
    chk("fwft_first", 32'(rd_data1), 32'hA);
    chk("fwft_valid", 32'(rd_valid1), 32'd1);
    cycle(1'b1, 4'hB, 1'b0, 1'b0, 1'b0);
    chk("fwft_hold", 32'(rd_data1), 32'hA);
    cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    chk("fwft_next", 32'(rd_data1), 32'hB);
    cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    chk("fwft_drained", 32'(rd_valid1), 32'd0);

    // Flush wins over simultaneous push and pop.
    for (int i = 0; i < 5; i++) cycle(1'b1, 4'(3 * i), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 4'hF, 1'b1, 1'b1, 1'b0);
    chk("flush_level", 32'(level0), 32'd0);
    chk("flush_empty", 32'(empty0), 32'd1);
    chk("flush_rv", 32'(rd_valid0), 32'd0);
    chk("flush_ovf", 32'(ovf0), 32'd0);
    chk("flush_unf", 32'(unf0), 32'd0);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 99) < 60, 4'($urandom), $urandom_range(0, 99) < 50,
            $urandom_range(0, 39) == 0, $urandom_range(0, 19) == 0);
    end

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'(i + 7), 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    wr_en = 1'b1;
    wr_data = 4'h9;
    rd_en = 1'b1;
    flush = 1'b0;
    clr_err = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_reset_state("async_rst");
    model_reset();
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    #1;
    check_reset_state("rst_held");
    rst = 1'b0;
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO. It is the general-purpose buffering block for datapaths that need configurable width and depth.
- Adds correct simultaneous push/pop, a fill-level output, almost-full/almost-empty thresholds and sticky overflow/underflow error flags.
- Adds a synchronous flush and an optional first-word-fall-through (FWFT) read mode.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2
AF_LEVEL, 14, almost_full asserted when level >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty asserted when level <= AE_LEVEL (0..DEPTH-1)
FWFT, 0, 0 = registered read (1-cycle latency); 1 = first-word-fall-through

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
flush  in  1  synchronous clear of FIFO contents
wr_en  in  1  push request
wr_data  in  DATA_W  push data
rd_en  in  1  pop request
rd_data  out  DATA_W  read data
rd_valid  out  1  rd_data holds a valid popped/head word
level  out  $clog2(DEPTH)+1  current number of stored entries, 0..DEPTH
full  out  1  level == DEPTH
empty  out  1  level == 0
almost_full  out  1  level >= AF_LEVEL
almost_empty  out  1  level <= AE_LEVEL
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty
clr_err  in  1  synchronous clear of overflow/underflow

Behaviour:
- Storage: DEPTH x DATA_W array; wr_ptr/rd_ptr are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Level is a separate register, so full and empty are unambiguous.
- Reset (rst=1, async):
  - wr_ptr=0, rd_ptr=0, level=0.
  - rd_data=0, rd_valid=0, overflow=0, underflow=0.
  - Hence empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? n/a : 0).
  - Memory contents are not reset.
- Flags: full, empty, almost_full and almost_empty are combinational decodes of the level register only. They reflect state after the most recent edge; they never depend on same-cycle wr_en/rd_en.
- Write accept: wr_en && !full.
  - Store wr_data at wr_ptr; wr_ptr+1.
- Read accept: rd_en && !empty. Acceptance uses the registered full/empty.
  - A write while full is rejected even if a read is accepted in the same cycle.
  - A read while empty is rejected even if a write is accepted in the same cycle.
- Level update: +1 on write only, -1 on read only, unchanged on both or neither.
- FWFT=0:
  - On read accept, rd_data <= mem[rd_ptr] and rd_valid <= 1 at the same edge, so data is available one cycle after rd_en.
  - Otherwise rd_valid <= 0 and rd_data holds its last value.
- FWFT=1:
  - rd_data = mem[rd_ptr] combinationally and rd_valid = !empty.
  - rd_en acts as an acknowledge/pop; the next word appears after the edge.
  - A word written into an empty FIFO is visible on rd_data the cycle after the write edge.
- Errors:
  - overflow <= 1 on wr_en && full.
  - underflow <= 1 on rd_en && empty.
  - Both are sticky until clr_err or rst.
  - If clr_err coincides with a new error event, the flag stays 1 (set wins).
- flush:
  - Sets wr_ptr=rd_ptr=level=0 and rd_valid=0.
  - Has priority over wr_en/rd_en in the same cycle; neither is accepted.
  - Does not clear overflow/underflow, and does not raise errors in that cycle.
- Reset mid-operation aborts immediately; no partial write is committed after rst rises.
- Pointer wrap: the entry order is preserved across any number of wraps.
- Threshold outputs are checked at elaboration: AF_LEVEL in 1..DEPTH and AE_LEVEL in 0..DEPTH-1, else $error.

Test Plan:
1. DEPTH=8, DATA_W=4, FWFT=0. After reset, write 1,2,3, then pop 3 times:
   - rd_data is 1,2,3, each one cycle after its rd_en with rd_valid=1.
   - level goes 3,2,1,0 and empty=1 at the end.
2. Fill with 8 writes (0..7):
   - full=1 and level=8; almost_full rises when level reaches AF_LEVEL.
   - A 9th write sets overflow=1 and the contents are unchanged.
   - clr_err returns overflow to 0.
3. With level=4, assert wr_en and rd_en together for 10 cycles:
   - level stays 4.
   - Output order matches input order across pointer wrap; no data loss.
4. Assert rd_en when empty while simultaneously writing 5:
   - underflow=1 and the read is rejected; rd_valid stays 0.
   - level=1, and the next read returns 5.
5. FWFT=1: write 0xA into an empty FIFO:
   - rd_data=0xA and rd_valid=1 the next cycle without rd_en.
   - Write 0xB, then pulse rd_en; rd_data=0xB after the edge.
6. Load 5 entries, then assert flush together with wr_en/rd_en:
   - Next cycle level=0, empty=1, rd_valid=0, no errors.
   - Assert rst mid-burst: all outputs take reset values immediately, without a clock edge.
